fp32_accum_ctrl: RTL and testbench

//  Initiator side of the fpadder operand/result interface.
//  - Accepts a stream of fp32 operands over a valid/ready handshake.
//  - Issues each operand to an external fixed-latency fpadder as add_y, with the

---
 rtl/fp32_accum_ctrl_pkg.sv | 21 ++
 rtl/fp32_accum_ctrl_if.sv | 40 ++++
 rtl/fp32_accum_ctrl.sv | 109 ++++++++++
 tb/tb_fp32_accum_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_accum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp32_pkg
// Brief  : Shared fp32 types and controller state encoding for fp32_accum_ctrl.
// Rev    : 1.0
// ============================================================================
package fp32_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_accum_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fp32_accum_ctrl_if
// Brief  : Operand stream, fpadder operand/result and status bundle.
// Rev    : 1.0
// ============================================================================
interface fp32_accum_ctrl_if
  import fp32_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  fp32_t            in_data;
  logic             in_ready;
  fp32_t            add_x;
  fp32_t            add_y;
  fp32_t            add_z;
  logic [1:0]       add_ovf;
  logic             busy;
  logic             done;
  fp32_t            sum;
  logic [1:0]       ovf_flags;

  // Accumulator view: consumes the stream and adder result, drives status.
  modport slave (
    input  start, len, in_valid, in_data, add_z, add_ovf,
    output in_ready, add_x, add_y, busy, done, sum, ovf_flags
  );

  // Environment view: data source plus the external fpadder.
  modport master (
    output start, len, in_valid, in_data, add_z, add_ovf,
    input  in_ready, add_x, add_y, busy, done, sum, ovf_flags
  );

endinterface
`default_nettype wire

// File: rtl/fp32_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fp32_accum_ctrl
// Brief  : Sums a stream of fp32 operands through an external fixed-latency
//          fpadder, reporting the final sum and sticky exception flags.
// Rev    : 1.0
// ============================================================================
module fp32_accum_ctrl
  import fp32_pkg::*;
#(
  parameter int ADD_LAT = 3,
  parameter int CNT_W   = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fp32_accum_ctrl_if.slave   bus
);

  localparam int               TMR_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ADD_LAT - 1);

  acc_state_t       state_q,     state_d;
  fp32_t            sum_q,       sum_d;
  logic [1:0]       flags_q,     flags_d;
  fp32_t            add_x_q,     add_x_d;
  fp32_t            add_y_q,     add_y_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TMR_W-1:0] timer_q,     timer_d;
  logic             busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    flags_d     = flags_q;
    add_x_d     = add_x_q;
    add_y_d     = add_y_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sum_d       = FP32_POS_ZERO;
          flags_d     = 2'b00;
          remaining_d = bus.len;
          busy_d      = 1'b1;
          state_d     = (bus.len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          add_x_d = sum_q;
          add_y_d = bus.in_data;
          timer_d = TMR_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Operands stay frozen until the adder result lands in the sum.
        if (timer_q == '0) begin
          sum_d       = bus.add_z;
          flags_d     = flags_q | bus.add_ovf;
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? DONE : LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sum_q       <= FP32_POS_ZERO;
      flags_q     <= 2'b00;
      add_x_q     <= FP32_POS_ZERO;
      add_y_q     <= FP32_POS_ZERO;
      remaining_q <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      add_x_q     <= add_x_d;
      add_y_q     <= add_y_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.done      = (state_q == DONE);
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.ovf_flags = flags_q;
  assign bus.add_x     = add_x_q;
  assign bus.add_y     = add_y_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fp32_accum_ctrl
// Brief  : Self-checking bench for fp32_accum_ctrl with a behavioural fpadder.
// Rev    : 1.0
// ============================================================================
module tb_fp32_accum_ctrl;
  import fp32_pkg::*;

  localparam int    ADD_LAT = 3;
  localparam int    CNT_W   = 8;
  localparam fp32_t QNAN    = 32'h7FC0_0000;
  localparam fp32_t ONE     = 32'h3F80_0000;

  typedef struct packed {
    logic [1:0] ovf;
    fp32_t      z;
  } add_res_t;

  typedef struct {
    string      nm;
    int         len;
    fp32_t      el [4];
    bit         rnd;
    fp32_t      exp_sum;
    logic [1:0] exp_flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  fp32_t job_q [$];
  vec_t  vecs [5];

  always #5 clk = ~clk;

  fp32_accum_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fp32_accum_ctrl #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- fp32 arithmetic reference (via IEEE double) -------------
  function automatic real f2r(input fp32_t f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic fp32_t r2f(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] m24;
    logic [28:0] rest;
    int          fe;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'b0};
    fe = int'(d[62:52]) - 896;
    if (fe <= 0) return {d[63], 31'b0};
    m    = {1'b1, d[51:0]};
    m24  = {1'b0, m[52:29]};
    rest = m[28:0];
    if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m24[0])) m24 = m24 + 25'd1;
    if (m24[24]) begin
      fe  = fe + 1;
      m24 = m24 >> 1;
    end
    if (fe >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], 8'(fe), m24[22:0]};
  endfunction

  function automatic add_res_t fadd(input fp32_t a, input fp32_t b);
    add_res_t r;
    bit a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) begin
      r.z = QNAN; r.ovf = 2'b11;
    end else if (a_inf) begin
      r.z = a; r.ovf = 2'b01;
    end else if (b_inf) begin
      r.z = b; r.ovf = 2'b01;
    end else begin
      r.z   = r2f(f2r(a) + f2r(b));
      r.ovf = (r.z[30:23] == 8'hFF) ? 2'b01 : 2'b00;
    end
    return r;
  endfunction

  // ---------------- fixed-latency fpadder model ------------------------------
  add_res_t pipe [ADD_LAT-1];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ADD_LAT-1; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= fadd(bus.add_x, bus.add_y);
      for (int i = 1; i < ADD_LAT-1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.add_z   = pipe[ADD_LAT-2].z;
  assign bus.add_ovf = pipe[ADD_LAT-2].ovf;

  // ---------------- checking helpers -----------------------------------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Operands must not move while the adder is working on them.
  logic  was_wait = 1'b0;
  fp32_t px = '0, py = '0;
  always @(negedge clk) begin
    if (rst && bus.busy && !bus.in_ready && !bus.done && was_wait) begin
      chk("wait_add_x_stable", bus.add_x, px);
      chk("wait_add_y_stable", bus.add_y, py);
    end
    was_wait <= rst && bus.busy && !bus.in_ready && !bus.done;
    px       <= bus.add_x;
    py       <= bus.add_y;
  end

  function automatic fp32_t rnd_fp();
    int k;
    k = $urandom_range(0, 15);
    if (k == 0) return {1'($urandom), 31'h7F80_0000};
    if (k == 1) return 32'h7FC0_0001;
    return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Runs one accumulation of job_q[0:L-1]; exp_cyc < 0 skips the latency check.
  task automatic run_job(input string nm, input int L, input bit rnd_valid, input bit noise,
                         input fp32_t exp_sum, input logic [1:0] exp_flags, input int exp_cyc);
    int    idx, readies, done_cyc, budget;
    bit    fin, hs_prev;
    fp32_t pref [$];
    pref.push_back(FP32_POS_ZERO);
    for (int i = 0; i < L; i++) pref.push_back(fadd(pref[i], job_q[i]).z);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.len      = CNT_W'(L);
    bus.in_valid = 1'b0;
    idx = 0; readies = 0; done_cyc = -1; fin = 1'b0; hs_prev = 1'b0;
    budget = (L + 2) * (ADD_LAT + 1) * 4 + 10;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      @(negedge clk);
      if (hs_prev) begin
        chk({nm, "_add_x"}, bus.add_x, pref[idx-1]);
        chk({nm, "_add_y"}, bus.add_y, job_q[idx-1]);
      end
      if (bus.done) begin
        fin      = 1'b1;
        done_cyc = cyc;
      end
      bus.start    = noise && !fin && ($urandom_range(0, 3) == 0);
      bus.len      = CNT_W'($urandom);
      if (bus.in_ready) readies++;
      bus.in_valid = (idx < L) && (!rnd_valid || $urandom_range(0, 1) == 1);
      bus.in_data  = (idx < L) ? job_q[idx] : fp32_t'($urandom);
      hs_prev      = bus.in_valid && bus.in_ready;
      if (hs_prev) idx++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk({nm, "_done_seen"}, 32'(fin), 32'd1);
    chk({nm, "_sum"}, bus.sum, exp_sum);
    chk({nm, "_flags"}, 32'(bus.ovf_flags), 32'(exp_flags));
    chk({nm, "_handshakes"}, 32'(idx), 32'(L));
    if (L == 0) chk({nm, "_ready_cycles"}, 32'(readies), 32'd0);
    if (exp_cyc >= 0) chk({nm, "_done_latency"}, 32'(done_cyc), 32'(exp_cyc));
    @(negedge clk);
    chk({nm, "_done_pulse_len"}, 32'(bus.done), 32'd0);
    chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({nm, "_sum_held"}, bus.sum, exp_sum);
  endtask

  task automatic set_vec(input int i, input string nm, input int len,
                         input fp32_t e0, input fp32_t e1, input fp32_t e2, input fp32_t e3,
                         input bit rnd, input fp32_t s, input logic [1:0] fl);
    vecs[i].nm = nm;  vecs[i].len = len;
    vecs[i].el[0] = e0; vecs[i].el[1] = e1; vecs[i].el[2] = e2; vecs[i].el[3] = e3;
    vecs[i].rnd = rnd; vecs[i].exp_sum = s; vecs[i].exp_flags = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fp32_t      ms;
    logic [1:0] mf;
    int         L, hs;
    bit         stop;
    add_res_t   r;

    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;

    set_vec(0, "t1_tenths", 2, 32'h3DCCCCCD, 32'h3E4CCCCD, 0, 0, 1'b0, 32'h3E99999A, 2'b00);
    set_vec(1, "t2_large",  2, 32'h461C42CD, 32'h461C40CD, 0, 0, 1'b0, 32'h469C41CD, 2'b00);
    set_vec(2, "t3_len0",   0, 0, 0, 0, 0,                          1'b0, 32'h0000_0000, 2'b00);
    set_vec(3, "t4_nan",    3, ONE, 32'h7F800003, ONE, 0,           1'b0, QNAN,          2'b11);
    set_vec(4, "t5_ones",   4, ONE, ONE, ONE, ONE,                  1'b1, 32'h4080_0000, 2'b00);

    repeat (3) @(negedge clk);
    chk("reset_sum", bus.sum, 32'h0);
    chk("reset_ctrl", {27'b0, bus.in_ready, bus.busy, bus.done, bus.ovf_flags}, 32'h0);
    chk("reset_add_x", bus.add_x, 32'h0);
    chk("reset_add_y", bus.add_y, 32'h0);
    rst = 1'b1;

    foreach (vecs[v]) begin
      job_q.delete();
      for (int i = 0; i < vecs[v].len; i++) job_q.push_back(vecs[v].el[i]);
      run_job(vecs[v].nm, vecs[v].len, vecs[v].rnd, 1'b0, vecs[v].exp_sum, vecs[v].exp_flags,
              vecs[v].rnd ? -1 : vecs[v].len * (ADD_LAT + 1));
    end

    // Longest run the count field allows.
    job_q.delete();
    for (int i = 0; i < 255; i++) job_q.push_back(ONE);
    run_job("len_max", 255, 1'b0, 1'b0, 32'h437F_0000, 2'b00, 255 * (ADD_LAT + 1));

    // Reset while the third operand is in the adder.
    @(negedge clk);
    bus.start = 1'b1; bus.len = CNT_W'(5);
    hs = 0; stop = 1'b0;
    for (int cyc = 0; cyc < 100 && !stop; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (hs == 3 && bus.busy && !bus.in_ready) stop = 1'b1;
      else begin
        bus.in_valid = 1'b1;
        bus.in_data  = ONE;
        if (bus.in_ready) hs++;
      end
    end
    bus.in_valid = 1'b0;
    chk("t6_reached_wait", 32'(stop), 32'd1);
    chk("t6_pre_reset_sum", bus.sum, 32'h4000_0000);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_sum", bus.sum, 32'h0);
    chk("t6_rst_ctrl", {27'b0, bus.in_ready, bus.busy, bus.done, bus.ovf_flags}, 32'h0);
    chk("t6_rst_operands", bus.add_x | bus.add_y, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_done_in_reset", 32'(bus.done), 32'd0);
    end
    rst = 1'b1;
    job_q.delete();
    for (int i = 0; i < 3; i++) job_q.push_back(ONE);
    run_job("t6_after_rst", 3, 1'b1, 1'b1, 32'h4040_0000, 2'b00, -1);

    // Random streams against a fold over the adder's arithmetic.
    for (int j = 0; j < 12; j++) begin
      L = $urandom_range(1, 6);
      job_q.delete();
      ms = FP32_POS_ZERO; mf = 2'b00;
      for (int i = 0; i < L; i++) begin
        job_q.push_back(rnd_fp());
        r  = fadd(ms, job_q[i]);
        ms = r.z;
        mf = mf | r.ovf;
      end
      run_job($sformatf("rand%0d", j), L, 1'b1, 1'b1, ms, mf, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
